// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, line constants and baud divisor helper
//   Used by the transmitter (uart_tx_streamer) and the receiver.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   UART_DATA_BITS = 8;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous first-word-fall-through FIFO
//   clk, rst        clock, asynchronous active-high reset (flushes contents)
//   push, wdata     write request and data (ignored when full)
//   pop             read request (ignored when empty)
//   rdata           head entry, valid whenever !empty
//   full, empty     occupancy flags
//   count           number of entries held
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign full    = count_q == CW'(DEPTH);
  assign empty   = count_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_q];
  assign count   = count_q;
  always_comb begin
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata;
endmodule

// File: rtl/uart_tx_streamer.sv
// uart_tx_streamer: buffered UART transmitter (8N1, or 8E1 with UART_TX_PARITY_EN)
//   clk, rst     clock, asynchronous active-high reset
//   tx_data      byte to send, sampled on the tx_valid && tx_ready handshake
//   tx_valid     producer offers tx_data
//   tx_ready     FIFO not full
//   TxD          registered serial line, idle high
//   busy         frame in progress or bytes queued
//   fifo_count   bytes waiting in the FIFO
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_streamer import uart_pkg::*; #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic                            TxD,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
  localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int BW  = $clog2(CPB + 1);
`ifdef UART_TX_PARITY_EN
  localparam uart_tx_state_e AFTER_DATA = PARITY;
`else
  localparam uart_tx_state_e AFTER_DATA = STOP;
`endif
  uart_tx_state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic txd_q, txd_d;
  logic [7:0] fifo_rdata;
  logic fifo_full, fifo_empty, pop, last;
  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .wdata (tx_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
  assign last     = baud_q == BW'(CPB - 1);
  // Popping on the last stop cycle chains frames with no idle gap.
  assign pop      = !fifo_empty && (state_q == IDLE || (state_q == STOP && last));
  assign tx_ready = !fifo_full;
  assign busy     = state_q != IDLE || !fifo_empty;
  assign TxD      = txd_q;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
  assign par_d = pop ? ^fifo_rdata : par_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) par_q <= 1'b0;
    else par_q <= par_d;
`endif
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    baud_d  = (state_q == IDLE || last) ? '0 : baud_q + 1'b1;
    if (pop) begin
      state_d = START;
      shift_d = fifo_rdata;
    end else if (last) begin
      if (state_q == START) begin
        state_d = DATA;
        bit_d   = '0;
      end else if (state_q == DATA) begin
        bit_d   = bit_q + 1'b1;
        shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
        state_d = bit_q == 3'(UART_DATA_BITS - 1) ? AFTER_DATA : DATA;
      end else if (state_q == PARITY) begin
        state_d = STOP;
      end else if (state_q == STOP) begin
        state_d = IDLE;
      end
    end
    // Line level follows the next state so TxD is registered with no extra lag.
    txd_d = state_d == START ? UART_START_BIT :
            state_d == DATA  ? shift_d[0] :
`ifdef UART_TX_PARITY_EN
            state_d == PARITY ? par_d :
`endif
            UART_STOP_BIT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
endmodule

// File: tb/tb_uart_tx_streamer.sv
// tb_uart_tx_streamer: scoreboard bench with a bit-centre UART line receiver
module tb_uart_tx_streamer;
  localparam int CPB = 100;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, TxD, busy;
  logic [4:0] fifo_count;

  always #5 clk = ~clk;

  uart_tx_streamer #(.CLK_FREQ_HZ(100_000_000), .BAUD_RATE(1_000_000), .FIFO_DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .TxD        (TxD),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int accepted = 0;
  int started = 0;
  int start_cyc[$];
  bit rx_active = 0;
  int rx_t = 0;
  logic [10:0] rx_bits = '0;
  bit pend = 0;
  int end_cyc = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Line receiver and scoreboard: decodes what TxD shows, then records the
  // handshake that will occur at the coming rising edge.
  always @(negedge clk) begin
    logic [7:0] b;
    cyc++;
    if (rst) begin
      rx_active = 0;
      exp_q.delete();
      accepted = 0;
      started = 0;
      pend = 0;
    end else begin
      if (!rx_active) begin
        if (TxD === 1'b0) begin
          rx_active = 1;
          rx_t = 0;
          started++;
          start_cyc.push_back(cyc);
          chk("fifo_count_at_frame_start", 32'(fifo_count), accepted - started);
          if (pend) chk("no_gap_between_frames", cyc, end_cyc + 1);
        end
      end else begin
        rx_t++;
        if (rx_t % CPB == CPB / 2) rx_bits[rx_t / CPB] = TxD;
        if (rx_t == NB * CPB - 1) begin
          rx_active = 0;
          end_cyc = cyc;
          pend = accepted > started;
          b = rx_bits[8:1];
          chk("start_bit", 32'(rx_bits[0]), 0);
          chk("stop_bit", 32'(rx_bits[NB-1]), 1);
          chk("frame_was_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            chk("frame_data", 32'(b), 32'(exp_q[0]));
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", 32'(rx_bits[9]), 32'(^exp_q[0]));
`endif
            void'(exp_q.pop_front());
          end
        end
      end
      if (tx_valid && tx_ready) begin
        exp_q.push_back(tx_data);
        accepted++;
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int n = 0;
    tx_valid = 1'b1;
    tx_data = d;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_ready && n < 5000);
    chk("tx_ready_within_budget", 32'(tx_ready), 1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 30000);
    @(negedge clk);
    chk("drained_busy", 32'(busy), 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, acc18, base;
    bit hs, seen_full;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_txd", 32'(TxD), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_fifo_count", 32'(fifo_count), 0);
    chk("reset_tx_ready", 32'(tx_ready), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Single byte: latency and frame length.
    tx_valid = 1'b1;
    tx_data = 8'hA5;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    @(negedge clk);
    chk("txd_high_on_accept_cycle", 32'(TxD), 1);
    chk("count_after_accept", 32'(fifo_count), 1);
    @(negedge clk);
    chk("txd_falls_next_edge", 32'(TxD), 0);
    chk("count_after_pop", 32'(fifo_count), 0);
    repeat (NB * CPB - 1) @(negedge clk);
    chk("busy_through_stop", 32'(busy), 1);
    @(negedge clk);
    chk("busy_drops_after_frame", 32'(busy), 0);
    chk("txd_idle_after_frame", 32'(TxD), 1);
    wait_idle();
    // Three bytes on consecutive cycles.
    tx_valid = 1'b1;
    tx_data = 8'h00;
    @(posedge clk);
    #1;
    tx_data = 8'hFF;
    @(posedge clk);
    #1;
    tx_data = 8'h3C;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    wait_idle();
    // Overfill: hold tx_valid for 18 bytes with data changing every cycle.
    acc = 0;
    acc18 = 0;
    seen_full = 0;
    base = start_cyc.size();
    tx_valid = 1'b1;
    tx_data = 8'($urandom);
    for (int n = 0; n < 20000 && acc < 18; n++) begin
      @(negedge clk);
      hs = tx_ready;
      if (acc == 17 && !seen_full) begin
        chk("ready_low_after_17", 32'(tx_ready), 0);
        chk("count_full_after_17", 32'(fifo_count), 16);
        seen_full = 1;
      end
      @(posedge clk);
      #1;
      if (hs) begin
        acc++;
        if (acc == 18) acc18 = cyc;
      end
      tx_data = 8'($urandom);
    end
    tx_valid = 1'b0;
    chk("accepted_18", acc, 18);
    chk("byte18_after_frame2_start", acc18, start_cyc.size() > base + 1 ? start_cyc[base+1] : -1);
    wait_idle();
    // Reset in the middle of the data bits.
    send(8'h81);
    repeat (300) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_reset_txd", 32'(TxD), 1);
    chk("mid_reset_count", 32'(fifo_count), 0);
    chk("mid_reset_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h55);
    wait_idle();
    // Parity patterns (odd and even number of ones).
    send(8'h07);
    wait_idle();
    send(8'h03);
    wait_idle();
    // tx_valid during reset must be ignored.
    rst = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'hAA;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("rst_valid_txd", 32'(TxD), 1);
      chk("rst_valid_count", 32'(fifo_count), 0);
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("after_rst_valid_count", 32'(fifo_count), 0);
    chk("after_rst_valid_busy", 32'(busy), 0);
    chk("after_rst_valid_txd", 32'(TxD), 1);
    @(posedge clk);
    #1;
    // Random bytes with random gaps.
    for (int i = 0; i < 8; i++) begin
      send(8'($urandom));
      repeat ($urandom_range(0, 3) * ((i % 3 == 2) ? 400 : 1)) @(posedge clk);
      #1;
    end
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
